pipo_load_arbiter: RTL and testbench
====================================

Name: pipo_load_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit parallel-in/parallel-out register among NUM_REQ requesters.
- Each requester presents a byte and raises req. The block grants one requester at a time and drives that requester's byte onto the register's data input with a single-cycle load pulse.
- It then holds ownership for HOLD_CYCLES so the owner can read the register output, and signals completion with done.
- Sits directly in front of the PIPO register: reg_load and reg_data_in connect to the register's load and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of the shared register.
- HOLD_CYCLES, 2, cycles the grant is held after the load cycle (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NUM_REQ  per-requester load request, level.
- req_data  input  NUM_REQ*WIDTH  packed request bytes; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  NUM_REQ  one-hot ownership, registered.
- grant_id  output  clog2(NUM_REQ)  binary index of current/last owner.
- done  output  NUM_REQ  one-cycle completion pulse to owner.
- busy  output  1  high while state != IDLE.
- reg_load  output  1  load strobe to shared register.
- reg_data_in  output  WIDTH  data to shared register.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - grant, done, reg_load, busy = 0.
  - grant_id=0, reg_data_in=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, LOAD, HOLD. All outputs are registered.
- IDLE, at a rising edge with req != 0:
  - Winner = first set bit of req searching (rr_ptr+1) mod NUM_REQ upward with wrap.
  - Registers update: state<=LOAD, grant<=onehot(winner), grant_id<=winner, rr_ptr<=winner, reg_data_in<=winner's req_data slice, reg_load<=1, busy<=1.
  - Latency: outputs are visible the cycle after req is sampled.
- IDLE with req == 0: remain in IDLE, all strobes 0.
- LOAD (exactly 1 cycle):
  - reg_load=1; the shared register captures reg_data_in at the closing edge.
  - Next: state<=HOLD, reg_load<=0, hold_cnt<=HOLD_CYCLES-1.
- HOLD (HOLD_CYCLES cycles):
  - grant stays asserted and reg_data_in stays stable.
  - hold_cnt decrements each cycle.
  - done[grant_id]=1 during the final HOLD cycle only (hold_cnt==0).
  - Next: IDLE.
- Return to IDLE: grant<=0, busy<=0.
  - grant_id and reg_data_in retain their last values.
  - At least one IDLE cycle separates consecutive grants.
  - Per-transaction occupancy: 1 + HOLD_CYCLES + 1 cycles.
- req and req_data are sampled only in IDLE.
  - Deasserting req during LOAD/HOLD does not abort; the transaction completes and done still pulses.
  - Changing req_data after the grant has no effect.
- The owner must drop req on done if it has no further request.
  - A still-high req is re-eligible, but the pointer has moved past it, so other pending requesters win first.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0...
  - No requester waits more than NUM_REQ-1 transactions.
- Invariants:
  - At most one bit of grant is set.
  - reg_load is high only in LOAD.
  - done is a subset of grant.
- Reset asserted mid-LOAD or mid-HOLD: outputs clear immediately (async), no done is issued, and arbitration restarts from requester 0 after reset release.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b1111 -> grant=0, reg_load=0, busy=0, reg_data_in=8'h00 throughout; after release, first grant=4'b0001.
- Single request: req=4'b0100, slice2=8'hAA -> next cycle grant=4'b0100, grant_id=2, reg_load=1, reg_data_in=8'hAA. Attached PIPO data_out=8'hAA one cycle later. done[2] pulses in cycle 3 after grant. grant=0 in cycle 4.
- All requesting: req=4'b1111 held with distinct bytes 8'h11/22/33/44 -> grant sequence 0,1,2,3,0. reg_data_in matches each owner's byte. Grants spaced 4 cycles apart (HOLD_CYCLES=2).
- Round-robin fairness: req0 held permanently, req2 raised during req0's HOLD -> next grant goes to 2, not 0. Then back to 0.
- Drop during hold: requester 1 granted, req[1] dropped in LOAD cycle -> HOLD completes, done[1] still pulses, then IDLE.
- Reset mid-operation: reset=0 during HOLD of requester 3 -> grant, done, busy go 0 without waiting for clk. After release with req=4'b1000, requester 3 is granted again.

Source files
------------

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter in front of a shared PIPO register: grants one requester,
// pulses a single load of its byte, holds ownership, then signals done.
module pipo_load_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       reg_load,
  output logic [WIDTH-1:0]           reg_data_in,
  output logic [1:0]                 fsm_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [HCW-1:0]     hold_cnt;
  logic [IDW-1:0]     winner;
  logic               hit;
  logic [IDW-1:0]     idx;
  logic [NUM_REQ-1:0] winner_oh;

  assign fsm_state = state;

  // Search starts just past the last owner and wraps, so the first hit is the
  // round-robin winner.
  always_comb begin
    winner = '0;
    hit    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!hit && req[idx]) begin
        winner = idx;
        hit    = 1'b1;
      end
    end
  end

  assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= IDW'(NUM_REQ - 1);
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      done        <= '0;
      busy        <= 1'b0;
      reg_load    <= 1'b0;
      reg_data_in <= '0;
    end else begin
      done     <= '0;
      reg_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state       <= ST_LOAD;
            grant       <= winner_oh;
            grant_id    <= winner;
            rr_ptr      <= winner;
            reg_data_in <= req_data[winner*WIDTH +: WIDTH];
            reg_load    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_LOAD: begin
          state    <= ST_HOLD;
          hold_cnt <= HCW'(HOLD_CYCLES - 1);
          // With a single hold cycle the first HOLD cycle is also the last.
          if (HOLD_CYCLES == 1) done <= grant;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HCW'(1)) done <= grant;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: vector table of transactions, random round-robin
// phase against a pointer model, and reset corner sequences.
module tb_pipo_load_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic [3:0]  done;
  logic        busy;
  logic        reg_load;
  logic [7:0]  reg_data_in;
  logic [1:0]  fsm_state;

  logic [7:0]  pipo_q;
  logic [13:0] exp_q[$];
  int          n_tests;
  int          n_fail;
  int          tb_ptr;

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  mid;
    logic [31:0] d;
    int          id;
  } vec_t;

  vec_t vecs[10];

  pipo_load_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .grant_id   (grant_id),
    .done       (done),
    .busy       (busy),
    .reg_load   (reg_load),
    .reg_data_in(reg_data_in),
    .fsm_state  (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared PIPO register the arbiter feeds
  always @(posedge clk) if (reg_load) pipo_q <= reg_data_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // scoreboard: a load pulse pops one expected grant
  always @(negedge clk) begin
    logic [13:0] e;
    if (reset) begin
      if (reg_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_grant", grant, e[13:10]);
          check("sb_grant_id", grant_id, e[9:8]);
          check("sb_data", reg_data_in, e[7:0]);
        end
      end
      check("inv_onehot", ((grant & (grant - 4'd1)) != 4'd0), 32'd0);
      check("inv_done_subset", done & ~grant, 32'd0);
      check("inv_load_state", reg_load && (fsm_state != 2'd1), 32'd0);
    end
  end

  // driver: one full transaction starting at a negedge with the DUT idle
  task automatic do_txn(input logic [3:0] r, input logic [3:0] mid,
                        input logic [31:0] d, input int id);
    logic [3:0] oh;
    logic [7:0] b;
    oh = 4'b0001 << id;
    b  = d[id*8 +: 8];
    req      = r;
    req_data = d;
    exp_q.push_back({oh, 2'(id), b});
    @(negedge clk);
    check("busy_load", busy, 32'd1);
    check("done_load", done, 32'd0);
    req      = mid;
    req_data = $urandom;
    @(negedge clk);
    check("load_hold1", reg_load, 32'd0);
    check("grant_hold1", grant, oh);
    check("data_hold1", reg_data_in, b);
    check("pipo_out", pipo_q, b);
    check("done_hold1", done, 32'd0);
    @(negedge clk);
    check("done_hold2", done, oh);
    check("grant_hold2", grant, oh);
    check("data_hold2", reg_data_in, b);
    @(negedge clk);
    check("grant_idle", grant, 32'd0);
    check("busy_idle", busy, 32'd0);
    check("done_idle", done, 32'd0);
    check("id_retained", grant_id, id);
    check("data_retained", reg_data_in, b);
    tb_ptr = id;
  endtask

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    int          id;
    n_tests  = 0;
    n_fail   = 0;
    tb_ptr   = 3;
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h4433_2211;

    vecs[0] = '{4'b1111, 4'b1111, 32'h4433_2211, 0};
    vecs[1] = '{4'b1111, 4'b1111, 32'h4433_2211, 1};
    vecs[2] = '{4'b1111, 4'b1111, 32'h4433_2211, 2};
    vecs[3] = '{4'b1111, 4'b1111, 32'h4433_2211, 3};
    vecs[4] = '{4'b1111, 4'b1111, 32'h4433_2211, 0};
    vecs[5] = '{4'b0100, 4'b0100, 32'h00AA_0000, 2};
    vecs[6] = '{4'b0001, 4'b0101, 32'h0000_0077, 0};
    vecs[7] = '{4'b0101, 4'b0101, 32'h0066_0077, 2};
    vecs[8] = '{4'b0101, 4'b0101, 32'h0066_0077, 0};
    vecs[9] = '{4'b0010, 4'b0000, 32'h0000_BE00, 1};

    // reset held with all requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_grant", grant, 32'd0);
      check("rst_load", reg_load, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_data", reg_data_in, 32'd0);
    end
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].r, vecs[i].mid, vecs[i].d, vecs[i].id);
      if (vecs[i].mid == 4'b0000) begin
        @(negedge clk);
        check("stay_idle_busy", busy, 32'd0);
        check("stay_idle_grant", grant, 32'd0);
      end
    end

    for (int i = 0; i < 8; i++) begin
      r  = 4'($urandom_range(1, 15));
      d  = $urandom;
      id = model_winner(r, tb_ptr);
      do_txn(r, r, d, id);
    end

    // reset asserted mid-HOLD, outputs must clear without a clock edge
    req      = 4'b1000;
    req_data = 32'hC300_0000;
    exp_q.push_back({4'b1000, 2'd3, 8'hC3});
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_grant", grant, 32'd0);
    check("async_done", done, 32'd0);
    check("async_busy", busy, 32'd0);
    check("async_load", reg_load, 32'd0);
    check("async_data", reg_data_in, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst2_grant", grant, 32'd0);
      check("rst2_done", done, 32'd0);
    end
    reset = 1'b1;
    do_txn(4'b1000, 4'b0000, 32'hC300_0000, 3);

    // after restart the pointer is back at requester 0's predecessor
    do_txn(4'b1001, 4'b0000, 32'h5A00_00E1, 0);

    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
